// File: rtl/axi2iob_pkg.sv
// Shared AXI response codes, FSM state encoding and arbitration direction flags
// for the AXI4-to-native-bus bridge.
package axi2iob_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic DIR_WRITE = 1'b0;
   localparam logic DIR_READ  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_WRESP = 2'd2,
      ST_READ  = 2'd3
   } state_e;

endpackage

// File: rtl/axi2iob_rbuf.sv
// One-entry R-channel buffer: a new beat may be loaded while the held one drains,
// so a continuously ready master sees one beat per cycle.
module axi2iob_rbuf #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              last_i,
   input  logic              ready_i,
   output logic              in_ready_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              last_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              last_q, last_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (push_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         last_d  = last_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign in_ready_o = !valid_q || ready_i;
   assign valid_o    = valid_q;
   assign data_o     = data_q;
   assign last_o     = last_q;

endmodule

// File: rtl/axi2iob.sv
// AXI4 slave (INCR, full-width beats, one burst outstanding) to a simple native
// valid/ready master bus, with round-robin arbitration between AW and AR.
module axi2iob
   import axi2iob_pkg::*;
#(
   parameter int ADDR_W   = 24,
   parameter int DATA_W   = 32,
   parameter int AXI_ID_W = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [AXI_ID_W-1:0]   s_axi_awid,
   input  logic [ADDR_W-1:0]     s_axi_awaddr,
   input  logic [7:0]            s_axi_awlen,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [DATA_W-1:0]     s_axi_wdata,
   input  logic [DATA_W/8-1:0]   s_axi_wstrb,
   input  logic                  s_axi_wlast,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [AXI_ID_W-1:0]   s_axi_bid,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [AXI_ID_W-1:0]   s_axi_arid,
   input  logic [ADDR_W-1:0]     s_axi_araddr,
   input  logic [7:0]            s_axi_arlen,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [AXI_ID_W-1:0]   s_axi_rid,
   output logic [DATA_W-1:0]     s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rlast,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic                  m_valid,
   output logic [ADDR_W-1:0]     m_addr,
   output logic [DATA_W-1:0]     m_wdata,
   output logic [DATA_W/8-1:0]   m_wstrb,
   input  logic [DATA_W-1:0]     m_rdata,
   input  logic                  m_ready,
   output logic                  busy
);

   localparam int BYTES = DATA_W / 8;
   localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BYTES);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

   state_e                state_q, state_d;
   logic [AXI_ID_W-1:0]   id_q, id_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic [8:0]            cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  dir_q, dir_d;

   logic both_v, take_w, last_beat, beats_left;
   logic rb_push, rb_in_ready;

   assign both_v     = s_axi_awvalid && s_axi_arvalid;
   assign take_w     = s_axi_awvalid && (!s_axi_arvalid || (dir_q == DIR_READ));
   assign last_beat  = (cnt_q == {1'b0, len_q});
   assign beats_left = (cnt_q <= {1'b0, len_q});

   // Next-state and native/AXI handshake decode.
   always_comb begin
      state_d       = state_q;
      id_d          = id_q;
      addr_d        = addr_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      err_d         = err_q;
      dir_d         = dir_q;
      s_axi_awready = 1'b0;
      s_axi_arready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      m_valid       = 1'b0;
      m_wdata       = '0;
      m_wstrb       = '0;
      rb_push       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // The loser of a simultaneous request is held off so it stays pending.
            s_axi_awready = rst_n && !(both_v && (dir_q == DIR_WRITE));
            s_axi_arready = rst_n && !(both_v && (dir_q == DIR_READ));
            if (take_w) begin
               id_d    = s_axi_awid;
               addr_d  = s_axi_awaddr & ALIGN_MASK;
               len_d   = s_axi_awlen;
               cnt_d   = 9'd0;
               err_d   = 1'b0;
               dir_d   = DIR_WRITE;
               state_d = ST_WRITE;
            end else if (s_axi_arvalid) begin
               id_d    = s_axi_arid;
               addr_d  = s_axi_araddr & ALIGN_MASK;
               len_d   = s_axi_arlen;
               cnt_d   = 9'd0;
               err_d   = 1'b0;
               dir_d   = DIR_READ;
               state_d = ST_READ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            m_valid      = s_axi_wvalid;
            m_wdata      = s_axi_wdata;
            m_wstrb      = s_axi_wstrb;
            s_axi_wready = m_ready;
            if (s_axi_wvalid && m_ready) begin
               addr_d = addr_q + ADDR_STEP;
               cnt_d  = cnt_q + 9'd1;
               err_d  = err_q || (s_axi_wlast != last_beat);
               if (last_beat) begin
                  state_d = ST_WRESP;
               end else begin
                  state_d = ST_WRITE;
               end
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_WRESP: begin
            s_axi_bvalid = 1'b1;
            if (s_axi_bready) begin
               err_d   = 1'b0;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WRESP;
            end
         end
         ST_READ: begin
            m_valid = beats_left && rb_in_ready;
            if (m_valid && m_ready) begin
               rb_push = 1'b1;
               addr_d  = addr_q + ADDR_STEP;
               cnt_d   = cnt_q + 9'd1;
            end else begin
               rb_push = 1'b0;
            end
            if (s_axi_rvalid && s_axi_rready && s_axi_rlast) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_READ;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Burst context registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= 8'd0;
         cnt_q   <= 9'd0;
         err_q   <= 1'b0;
         dir_q   <= DIR_READ;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         dir_q   <= dir_d;
      end
   end

   axi2iob_rbuf #(.DATA_W(DATA_W)) u_rbuf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (rb_push),
      .data_i     (m_rdata),
      .last_i     (last_beat),
      .ready_i    (s_axi_rready),
      .in_ready_o (rb_in_ready),
      .valid_o    (s_axi_rvalid),
      .data_o     (s_axi_rdata),
      .last_o     (s_axi_rlast)
   );

   assign s_axi_bid   = id_q;
   assign s_axi_bresp = err_q ? RESP_SLVERR : RESP_OKAY;
   assign s_axi_rid   = id_q;
   assign s_axi_rresp = RESP_OKAY;
   assign m_addr      = addr_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi2iob.sv
// Randomized scoreboard bench for axi2iob: expectations are queued from a
// word-addressed memory model, a negedge monitor pops and compares them.
module tb_axi2iob;

   typedef struct packed { logic [23:0] addr; logic [31:0] data; logic [3:0] strb; } nw_t;
   typedef struct packed { logic id; logic [31:0] data; logic last; } r_t;
   typedef struct packed { logic id; logic [1:0] resp; } b_t;

   logic clk = 1'b0;
   logic rst_n;
   logic        s_axi_awid, s_axi_awvalid, s_axi_awready;
   logic [23:0] s_axi_awaddr;
   logic [7:0]  s_axi_awlen;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
   logic        s_axi_bid, s_axi_bvalid, s_axi_bready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_arid, s_axi_arvalid, s_axi_arready;
   logic [23:0] s_axi_araddr;
   logic [7:0]  s_axi_arlen;
   logic        s_axi_rid, s_axi_rlast, s_axi_rvalid, s_axi_rready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        m_valid, m_ready, busy;
   logic [23:0] m_addr;
   logic [31:0] m_wdata, m_rdata;
   logic [3:0]  m_wstrb;

   nw_t         exp_nw[$];
   logic [23:0] exp_nr[$];
   r_t          exp_r[$];
   b_t          exp_b[$];
   bit          serve_log[$];
   logic [31:0] ref_mem[int];
   logic [31:0] smem[0:16383];

   int n_chk = 0, n_fail = 0, r_beats = 0, nw_beats = 0;
   int mr_mode = 0, rr_mode = 0, br_mode = 0;
   bit w_gaps = 1'b0;

   always #5 clk = ~clk;

   axi2iob dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready),
      .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy)
   );

   // Native slave: combinational read data from the slave memory.
   assign m_rdata = smem[m_addr[15:2]];

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_rd(logic [23:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return 32'd0;
   endfunction

   function automatic logic pick_ready(int mode, bit ph);
      case (mode)
         0: return 1'b1;
         1: return ph;
         default: return ($urandom_range(0, 1) == 1);
      endcase
   endfunction

   // Ready drivers for the native slave, R and B channels.
   initial begin
      bit ph;
      ph = 1'b0;
      m_ready = 1'b1; s_axi_rready = 1'b1; s_axi_bready = 1'b1;
      forever begin
         @(posedge clk); #1;
         ph = ~ph;
         m_ready      = pick_ready(mr_mode, ph);
         s_axi_rready = pick_ready(rr_mode, ph);
         s_axi_bready = pick_ready(br_mode, ph);
      end
   end

   // Monitor: pops scoreboard entries on every handshake seen before the next edge.
   initial begin
      logic [23:0] prev_addr;
      bit prev_stall;
      nw_t en; r_t er; b_t eb;
      for (int i = 0; i < 16384; i++) smem[i] = 32'd0;
      prev_stall = 1'b0; prev_addr = 24'd0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && m_valid) chk("m_addr_stable", m_addr, prev_addr);
            prev_stall = m_valid && !m_ready;
            prev_addr  = m_addr;
            if (s_axi_awvalid && s_axi_awready) serve_log.push_back(1'b0);
            if (s_axi_arvalid && s_axi_arready) serve_log.push_back(1'b1);
            if (m_valid && m_ready && m_wstrb != 4'd0) begin
               nw_beats++;
               chk("nw_expected", exp_nw.size() != 0, 1'b1);
               if (exp_nw.size() != 0) begin
                  en = exp_nw.pop_front();
                  chk("nw_addr", m_addr, en.addr);
                  chk("nw_data", m_wdata, en.data);
                  chk("nw_strb", m_wstrb, en.strb);
               end
               smem[m_addr[15:2]] = merge(smem[m_addr[15:2]], m_wdata, m_wstrb);
            end else if (m_valid && m_ready) begin
               chk("nr_expected", exp_nr.size() != 0, 1'b1);
               if (exp_nr.size() != 0) chk("nr_addr", m_addr, exp_nr.pop_front());
            end
            if (s_axi_rvalid && s_axi_rready) begin
               r_beats++;
               chk("r_expected", exp_r.size() != 0, 1'b1);
               if (exp_r.size() != 0) begin
                  er = exp_r.pop_front();
                  chk("rid", s_axi_rid, er.id);
                  chk("rdata", s_axi_rdata, er.data);
                  chk("rlast", s_axi_rlast, er.last);
                  chk("rresp", s_axi_rresp, 2'b00);
               end
            end
            if (s_axi_bvalid && s_axi_bready) begin
               chk("b_expected", exp_b.size() != 0, 1'b1);
               if (exp_b.size() != 0) begin
                  eb = exp_b.pop_front();
                  chk("bid", s_axi_bid, eb.id);
                  chk("bresp", s_axi_bresp, eb.resp);
               end
            end
         end
      end
   end

   task automatic aw_issue(input logic id, input logic [23:0] a, input logic [7:0] len);
      int c;
      s_axi_awid = id; s_axi_awaddr = a; s_axi_awlen = len; s_axi_awvalid = 1'b1;
      for (c = 0; c < 5000; c++) begin @(negedge clk); if (s_axi_awready) break; end
      chk("aw_handshake", c < 5000, 1'b1);
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
   endtask

   task automatic ar_issue(input logic id, input logic [23:0] a, input logic [7:0] len);
      int c;
      s_axi_arid = id; s_axi_araddr = a; s_axi_arlen = len; s_axi_arvalid = 1'b1;
      for (c = 0; c < 5000; c++) begin @(negedge clk); if (s_axi_arready) break; end
      chk("ar_handshake", c < 5000, 1'b1);
      @(posedge clk); #1;
      s_axi_arvalid = 1'b0;
   endtask

   task automatic do_write(input logic id, input logic [23:0] a, input logic [7:0] len,
                           input int base, input int bad, input bit rnd_strb);
      logic [23:0] aa;
      logic [31:0] d[$];
      logic [3:0]  s[$];
      b_t eb;
      nw_t en;
      int n0, c;
      aa = a & 24'hFFFFFC;
      for (int i = 0; i <= int'(len); i++) begin
         en.addr = aa;
         en.data = (base >= 0) ? 32'(base + i) : $urandom;
         en.strb = rnd_strb ? 4'($urandom_range(1, 15)) : 4'hF;
         d.push_back(en.data); s.push_back(en.strb);
         exp_nw.push_back(en);
         ref_mem[int'(aa)] = merge(ref_rd(aa), en.data, en.strb);
         aa = aa + 24'd4;
      end
      eb.id = id;
      eb.resp = (bad >= 0 && bad < int'(len)) ? 2'b10 : 2'b00;
      exp_b.push_back(eb);
      n0 = nw_beats;
      aw_issue(id, a, len);
      for (int i = 0; i <= int'(len); i++) begin
         if (w_gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
         s_axi_wdata = d[i]; s_axi_wstrb = s[i];
         s_axi_wlast = (i == int'(len)) || (i == bad);
         s_axi_wvalid = 1'b1;
         for (c = 0; c < 5000; c++) begin @(negedge clk); if (s_axi_wready) break; end
         chk("w_beat_accepted", c < 5000, 1'b1);
         @(posedge clk); #1;
         s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      end
      for (c = 0; c < 20000; c++) begin @(negedge clk); if (exp_b.size() == 0) break; end
      chk("b_done", exp_b.size(), 0);
      chk("nw_all_seen", exp_nw.size(), 0);
      chk("nw_beat_count", nw_beats - n0, int'(len) + 1);
   endtask

   task automatic push_read(input logic id, input logic [23:0] a, input logic [7:0] len);
      logic [23:0] aa;
      r_t er;
      aa = a & 24'hFFFFFC;
      for (int i = 0; i <= int'(len); i++) begin
         exp_nr.push_back(aa);
         er.id = id; er.data = ref_rd(aa); er.last = (i == int'(len));
         exp_r.push_back(er);
         aa = aa + 24'd4;
      end
   endtask

   task automatic do_read(input logic id, input logic [23:0] a, input logic [7:0] len);
      int n0, c;
      n0 = r_beats;
      push_read(id, a, len);
      ar_issue(id, a, len);
      for (c = 0; c < 20000; c++) begin @(negedge clk); if (exp_r.size() == 0) break; end
      chk("r_done", exp_r.size(), 0);
      chk("nr_all_seen", exp_nr.size(), 0);
      chk("r_beat_count", r_beats - n0, int'(len) + 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] a;
      logic [7:0]  len;
      logic [23:0] wr_bases[$];
      int bad, c, r0;
      rst_n = 1'b0;
      s_axi_awid = 1'b0; s_axi_awaddr = 24'd0; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b0;
      s_axi_wdata = 32'd0; s_axi_wstrb = 4'd0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
      s_axi_arid = 1'b0; s_axi_araddr = 24'd0; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b0;
      #12;
      chk("rst_awready", s_axi_awready, 1'b0);
      chk("rst_arready", s_axi_arready, 1'b0);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_bvalid", s_axi_bvalid, 1'b0);
      chk("rst_rvalid", s_axi_rvalid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_bresp", s_axi_bresp, 2'b00);
      chk("rst_rdata", s_axi_rdata, 32'd0);
      @(posedge clk); #3 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_awready", s_axi_awready, 1'b1);
      chk("post_rst_arready", s_axi_arready, 1'b1);
      @(posedge clk); #1;

      // Simultaneous AW/AR, twice: expected order write, read, write, read.
      fork
         do_write(1'b0, 24'h001000, 8'd3, -1, -1, 1'b0);
         do_read(1'b1, 24'h002000, 8'd3);
      join
      fork
         do_write(1'b1, 24'h001100, 8'd3, -1, -1, 1'b0);
         do_read(1'b0, 24'h002100, 8'd3);
      join
      chk("serve_log_len", serve_log.size(), 4);
      if (serve_log.size() == 4) begin
         chk("serve0_write", serve_log[0], 1'b0);
         chk("serve1_read", serve_log[1], 1'b1);
         chk("serve2_write", serve_log[2], 1'b0);
         chk("serve3_read", serve_log[3], 1'b1);
      end

      do_write(1'b0, 24'h007FD8, 8'd15, 32, -1, 1'b0);
      rr_mode = 1;
      do_read(1'b1, 24'h007FD8, 8'd15);
      rr_mode = 0;

      do_write(1'b1, 24'h003000, 8'd3, -1, 1, 1'b0);
      do_write(1'b0, 24'h003100, 8'd3, -1, -1, 1'b0);

      mr_mode = 2; rr_mode = 2;
      do_write(1'b0, 24'h004000, 8'd0, -1, -1, 1'b0);
      do_read(1'b1, 24'h004000, 8'd0);
      do_write(1'b1, 24'h005000, 8'd255, -1, -1, 1'b1);
      do_read(1'b0, 24'h005000, 8'd255);
      mr_mode = 0; rr_mode = 0;

      // Reset in the middle of a read burst, then repeat the read.
      r0 = r_beats;
      push_read(1'b1, 24'h007FD8, 8'd15);
      ar_issue(1'b1, 24'h007FD8, 8'd15);
      for (c = 0; c < 5000; c++) begin @(negedge clk); if (r_beats >= r0 + 5) break; end
      chk("reset_wait_beat5", r_beats >= r0 + 5, 1'b1);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("midrst_m_valid", m_valid, 1'b0);
      chk("midrst_rvalid", s_axi_rvalid, 1'b0);
      chk("midrst_bvalid", s_axi_bvalid, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_arready", s_axi_arready, 1'b0);
      exp_r.delete(); exp_nr.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("after_rst_awready", s_axi_awready, 1'b1);
      chk("after_rst_arready", s_axi_arready, 1'b1);
      chk("after_rst_m_valid", m_valid, 1'b0);
      @(posedge clk); #1;
      do_read(1'b0, 24'h007FD8, 8'd15);

      for (int k = 0; k < 24; k++) begin
         mr_mode = $urandom_range(0, 2); rr_mode = $urandom_range(0, 2);
         br_mode = $urandom_range(0, 2); w_gaps = 1'($urandom_range(0, 1));
         len = 8'($urandom_range(0, 15));
         if (wr_bases.size() == 0 || $urandom_range(0, 1) == 0) begin
            a = 24'($urandom_range(0, 16'hEFFF));
            bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            do_write(1'($urandom_range(0, 1)), a, len, -1, bad, 1'b1);
            wr_bases.push_back(a);
         end else begin
            a = wr_bases[$urandom_range(0, wr_bases.size() - 1)];
            do_read(1'($urandom_range(0, 1)), a, len);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
